// File: rtl/reg_file_mp_pkg.sv
// Shared RV32 register-file constants: default widths and the hardwired zero register index.
package reg_file_mp_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);
    localparam int REG_ZERO  = 0;

endpackage

// File: rtl/reg_file_mp_scoreboard.sv
// Per-register busy scoreboard: writes clear, reservations set (set wins), NRD lookup ports.
module reg_scoreboard
    import reg_file_mp_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int AW       = $clog2(NREGS),
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy,
    output logic [NREGS-1:0]  busy_vec
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_nxt;

    // NOTE: every always_comb output starts from a default so no path leaves it unassigned (no latch).
    always_comb begin
        busy_nxt = busy_q;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w]) busy_nxt[wr_addr[w*AW +: AW]] = 1'b0;
        end
        // A new producer supersedes the one completing in the same cycle.
        if (rsv_en) busy_nxt[rsv_addr] = 1'b1;
        if (ZERO_REG) busy_nxt[REG_ZERO] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_nxt;
    end

    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd_busy[i] = busy_q[rd_addr[i*AW +: AW]];
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with write collision resolution, optional bypass and busy scoreboard.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int AW       = $clog2(NREGS),
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    output logic [NREGS-1:0]    busy_vec
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [XLEN-1:0]  wd   [NREGS];
    logic [NREGS-1:0] we;
    logic [NRD-1:0]   byp_hit;
    logic [NRD-1:0]   sb_busy;

    // Per-register write select; later (higher-index) ports override earlier ones on collision.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            we[r] = 1'b0;
            wd[r] = '0;
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && wr_addr[w*AW +: AW] == AW'(r)) begin
                    we[r] = 1'b1;
                    wd[r] = wr_data[w*XLEN +: XLEN];
                end
            end
            if (ZERO_REG && r == REG_ZERO) we[r] = 1'b0;
        end
    end

    // NOTE: storage is a reset flop array rather than a RAM, since every register must clear asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (we[r]) regs[r] <= wd[r];
            end
        end
    end

    // Bypass is suppressed while reset is asserted so reads show the cleared state.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            logic [AW-1:0]   ra;
            logic [XLEN-1:0] data;
            logic            hit;
            ra   = rd_addr[i*AW +: AW];
            data = regs[ra];
            hit  = 1'b0;
            for (int w = 0; w < NWR; w++) begin
                if (BYPASS && rst_n && wr_en[w] && wr_addr[w*AW +: AW] == ra) begin
                    hit  = 1'b1;
                    data = wr_data[w*XLEN +: XLEN];
                end
            end
            if (ZERO_REG && ra == AW'(REG_ZERO)) begin
                hit  = 1'b0;
                data = '0;
            end
            rd_data[i*XLEN +: XLEN] = data;
            byp_hit[i]              = hit;
        end
    end

    reg_scoreboard #(
        .NREGS    (NREGS),
        .AW       (AW),
        .NRD      (NRD),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (sb_busy),
        .busy_vec (busy_vec)
    );

    assign rd_busy = sb_busy & ~byp_hit;

endmodule

// File: tb/tb_reg_file_mp.sv
// Checks reg_file_mp with and without bypass against an array-based model of the register file rules.
module tb_reg_file_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int NWR   = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;

    logic [NRD*XLEN-1:0] rd_data_b, rd_data_n;
    logic [NRD-1:0]      rd_busy_b, rd_busy_n;
    logic [NREGS-1:0]    busy_vec_b, busy_vec_n;

    logic [XLEN-1:0]  m_mem [NREGS];
    logic [NREGS-1:0] m_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD), .NWR(NWR), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy_vec(busy_vec_b)
    );

    reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD), .NWR(NWR), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_n (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy_vec(busy_vec_n)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) m_mem[r] = '0;
        m_busy = '0;
    endtask

    function automatic logic [XLEN-1:0] exp_data(input int i, input bit byp);
        int              ra;
        logic [XLEN-1:0] v;
        ra = int'(rd_addr[i*AW +: AW]);
        if (ra == 0) return '0;
        v = m_mem[ra];
        if (byp) begin
            for (int w = 0; w < NWR; w++)
                if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == ra) v = wr_data[w*XLEN +: XLEN];
        end
        return v;
    endfunction

    function automatic logic exp_busy(input int i, input bit byp);
        int ra;
        ra = int'(rd_addr[i*AW +: AW]);
        if (ra == 0) return 1'b0;
        if (byp) begin
            for (int w = 0; w < NWR; w++)
                if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == ra) return 1'b0;
        end
        return m_busy[ra];
    endfunction

    task automatic check_outputs(input string tag);
        for (int i = 0; i < NRD; i++) begin
            check($sformatf("%s rd%0d data byp", tag, i), rd_data_b[i*XLEN +: XLEN], exp_data(i, 1'b1));
            check($sformatf("%s rd%0d data nobyp", tag, i), rd_data_n[i*XLEN +: XLEN], exp_data(i, 1'b0));
            check($sformatf("%s rd%0d busy byp", tag, i), rd_busy_b[i], exp_busy(i, 1'b1));
            check($sformatf("%s rd%0d busy nobyp", tag, i), rd_busy_n[i], exp_busy(i, 1'b0));
        end
        check($sformatf("%s busy_vec byp", tag), busy_vec_b, m_busy);
        check($sformatf("%s busy_vec nobyp", tag), busy_vec_n, m_busy);
    endtask

    // Writes apply in port order so the highest port lands last; a reservation is applied after writes.
    task automatic model_commit();
        for (int w = 0; w < NWR; w++) begin
            int a;
            a = int'(wr_addr[w*AW +: AW]);
            if (wr_en[w] && a != 0) begin
                m_mem[a]  = wr_data[w*XLEN +: XLEN];
                m_busy[a] = 1'b0;
            end
        end
        if (rsv_en && rsv_addr != '0) m_busy[rsv_addr] = 1'b1;
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        check_outputs(tag);
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle();
        wr_en  = '0;
        rsv_en = 1'b0;
    endtask

    task automatic wr(input int p, input int a, input logic [XLEN-1:0] d);
        wr_en[p]               = 1'b1;
        wr_addr[p*AW +: AW]    = AW'(a);
        wr_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic rd(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic rsv(input int a);
        rsv_en   = 1'b1;
        rsv_addr = AW'(a);
    endtask

    initial begin
        rst_n    = 1'b0;
        rd_addr  = '0;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_addr = '0;
        idle();
        model_reset();
        #2;
        rd(0, 5);
        rd(1, 9);
        #1;
        check_outputs("reset0");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write collision on r7: port 1 wins.
        wr(0, 7, 32'h11);
        wr(1, 7, 32'h22);
        rd(0, 7);
        rd(1, 8);
        cycle("coll");
        idle();
        #1;
        check("coll r7", rd_data_n[0 +: XLEN], 32'h22);

        // Distinct targets both land.
        wr(0, 7, 32'h33);
        wr(1, 8, 32'h44);
        cycle("dual");
        idle();
        #1;
        check("dual r7", rd_data_n[0 +: XLEN], 32'h33);
        check("dual r8", rd_data_n[XLEN +: XLEN], 32'h44);

        // Bypass versus registered read.
        wr(0, 3, 32'h5);
        cycle("pre r3");
        idle();
        wr(0, 3, 32'h1234);
        rd(0, 3);
        #1;
        check("bypass same cycle", rd_data_b[0 +: XLEN], 32'h1234);
        check("nobypass old value", rd_data_n[0 +: XLEN], 32'h5);
        cycle("bypass");
        idle();
        #1;
        check("nobypass next cycle", rd_data_n[0 +: XLEN], 32'h1234);

        // Register 0 stays zero and never busy.
        wr(0, 0, 32'hFFFF_FFFF);
        rsv(0);
        rd(0, 0);
        cycle("zero");
        idle();
        #1;
        check("zero read", rd_data_b[0 +: XLEN], 32'h0);
        check("zero busy", busy_vec_b[0], 1'b0);

        // Reservation, then completion.
        rsv(9);
        rd(0, 9);
        cycle("rsv9");
        idle();
        #1;
        check("rsv9 busy byp", rd_busy_b[0], 1'b1);
        check("rsv9 busy nobyp", rd_busy_n[0], 1'b1);
        wr(0, 9, 32'h99);
        #1;
        check("wr9 bypass clears rd_busy", rd_busy_b[0], 1'b0);
        check("wr9 nobyp still busy", rd_busy_n[0], 1'b1);
        cycle("wr9");
        idle();
        #1;
        check("wr9 busy cleared", busy_vec_b[9], 1'b0);

        // Same-edge reserve and write: busy stays set, data lands.
        rsv(9);
        wr(1, 9, 32'hAB);
        cycle("setclr");
        idle();
        #1;
        check("setclr busy", busy_vec_b[9], 1'b1);
        check("setclr data", rd_data_n[0 +: XLEN], 32'hAB);

        // Mid-cycle asynchronous reset.
        wr(0, 5, 32'hDEAD_BEEF);
        rsv(12);
        cycle("pre reset");
        idle();
        rd(0, 5);
        #1;
        check("pre reset r5", rd_data_n[0 +: XLEN], 32'hDEAD_BEEF);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("reset r5 byp", rd_data_b[0 +: XLEN], 32'h0);
        check("reset r5 nobyp", rd_data_n[0 +: XLEN], 32'h0);
        check("reset busy_vec", busy_vec_b, '0);
        wr(0, 6, 32'h77);
        rsv(6);
        rd(1, 6);
        #1;
        check("reset no bypass", rd_data_b[XLEN +: XLEN], 32'h0);
        @(posedge clk);
        #1;
        check("reset write discarded", rd_data_n[XLEN +: XLEN], 32'h0);
        check("reset rsv discarded", busy_vec_n, '0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle("post reset");

        // Randomized traffic over a narrow address range to provoke collisions and bypass hits.
        for (int n = 0; n < 300; n++) begin
            for (int w = 0; w < NWR; w++) begin
                wr_en[w]                = 1'($urandom_range(0, 1));
                wr_addr[w*AW +: AW]     = AW'($urandom_range(0, 15));
                wr_data[w*XLEN +: XLEN] = $urandom;
            end
            rsv_en   = ($urandom_range(0, 2) == 0);
            rsv_addr = AW'($urandom_range(0, 15));
            for (int i = 0; i < NRD; i++) begin
                if ($urandom_range(0, 3) == 0) rd_addr[i*AW +: AW] = wr_addr[($urandom_range(0, NWR - 1))*AW +: AW];
                else                           rd_addr[i*AW +: AW] = AW'($urandom_range(0, 15));
            end
            cycle($sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
